// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: owns the fetch PC, reads the single-cycle instruction
// memory, buffers {pc, word} pairs in a circular prefetch queue for decode.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        halted
);

   localparam int            AW   = $clog2(QDEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(QDEPTH);

   logic [31:0]   fetch_pc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic          halt_q;

   logic [31:0]   q_pc   [QDEPTH];
   logic [31:0]   q_data [QDEPTH];

   logic          pop;
   logic          push;
   logic          can_fetch;
   logic          zero_word;

   // Word alignment of redirect targets is enforced by dropping the low bits.
   logic          unused_redirect_lsb;
   assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

   assign inst_valid = (count != '0) & !redirect_valid;
   assign pop        = inst_valid & inst_ready;
   assign can_fetch  = !rst & !halt_q & !redirect_valid & ((count != FULL) | pop);
   assign zero_word  = (imem_rdata == 32'h0);
   assign push       = can_fetch & !zero_word;

   assign imem_req   = can_fetch;
   assign imem_addr  = fetch_pc;
   assign halted     = halt_q;
   assign inst_data  = q_data[head];
   assign inst_pc    = q_pc[head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         halt_q   <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect flushes the queue and restarts fetch at the aligned target.
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         halt_q   <= 1'b0;
      end else begin
         if (push) begin
            tail     <= tail + 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (can_fetch && zero_word) begin
            halt_q <= 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: queue storage carries no reset; head/tail/count alone define which
   // entries are live, so stale data is never observable.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[tail]   <= fetch_pc;
         q_data[tail] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic,
// all decode-side deliveries checked by a scoreboard against an instruction-stream model.
module tb_instruction_fetch_unit;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_data, inst_pc;
   logic        imem_req, redirect_valid, inst_valid, inst_ready, halted;
   logic [31:0] mem [256];

   assign imem_rdata = mem[imem_addr[9:2]];

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .halted(halted)
   );

   logic        rst2;
   logic [31:0] imem_addr2, imem_rdata2, inst_data2, inst_pc2;
   logic        imem_req2, inst_valid2, halted2;
   logic        redirect_valid2 = 1'b0;
   logic [31:0] redirect_pc2    = 32'h0;
   logic        inst_ready2     = 1'b1;
   logic [31:0] mem2 [256];

   assign imem_rdata2 = mem2[imem_addr2[9:2]];

   instruction_fetch_unit #(.RESET_PC(WRAP_PC), .QDEPTH(4)) dut2 (
      .clk(clk), .rst(rst2),
      .imem_addr(imem_addr2), .imem_req(imem_req2), .imem_rdata(imem_rdata2),
      .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
      .inst_valid(inst_valid2), .inst_data(inst_data2), .inst_pc(inst_pc2),
      .inst_ready(inst_ready2), .halted(halted2)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the instruction stream decode must see is the memory walked
   // word by word from the last restart point, stopping at the first zero word.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] m_pc;
   bit          m_halt;

   function automatic void fill();
      logic [31:0] w;
      ent_t        e;
      while (exp_q.size() < 8 && !m_halt) begin
         w = mem[m_pc[9:2]];
         if (w == 32'h0) begin
            m_halt = 1'b1;
         end else begin
            e.pc   = m_pc;
            e.data = w;
            exp_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
   endfunction

   function automatic void restart(input logic [31:0] pc);
      exp_q.delete();
      m_pc   = {pc[31:2], 2'b00};
      m_halt = 1'b0;
      fill();
   endfunction

   // Scoreboard monitor: every presented head entry must match the stream front.
   always @(negedge clk) begin
      if (!rst && inst_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_extra: got pc %h data %h, expected no instruction", inst_pc, inst_data);
         end else begin
            check("sb_pc", inst_pc, exp_q[0].pc);
            check("sb_data", inst_data, exp_q[0].data);
            if (inst_ready) begin
               void'(exp_q.pop_front());
               fill();
            end
         end
      end
   end

   task automatic reset_dut();
      @(posedge clk); #1;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      restart(32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_halt(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (!(halted && !inst_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_halted"}, 32'(halted), 32'd1);
      check({name, "_drained"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 32'h0;
         mem2[i] = 32'h0;
      end
      mem[0] = 32'h00122083; mem[1] = 32'h00422403;
      mem[2] = 32'h0080c3b3; mem[3] = 32'h0070c463;
      mem[4] = 32'h00422483; mem[5] = 32'h0074a3a3;
      mem[6] = 32'h00408613; mem[7] = 32'h01008767;
      mem2[8'hFE] = 32'h00100093;
      mem2[8'hFF] = 32'h00200113;
      mem2[8'h00] = 32'h00300193;

      rst = 1'b1; rst2 = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
      restart(32'h0);

      // Reset state and in-order streaming at full throughput.
      @(negedge clk);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_imem_addr", imem_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t1_first_req", 32'(imem_req), 32'd1);
      check("t1_first_addr", imem_addr, 32'h0);
      check("t1_not_valid_yet", 32'(inst_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t1_valid", 32'(inst_valid), 32'd1);
         check("t1_pc", inst_pc, 32'(4 * i));
         if (i == 0) check("t1_first_data", inst_data, 32'h00122083);
      end
      @(negedge clk);
      check("t1_halted", 32'(halted), 32'd1);
      check("t1_halt_req", 32'(imem_req), 32'd0);
      check("t1_halt_addr", imem_addr, 32'h20);
      check("t1_valid_drop", 32'(inst_valid), 32'd0);
      check("t1_drained", exp_q.size(), 32'd0);

      // Backpressure from reset: four pushes, then fetch stalls at 0x10.
      inst_ready = 1'b0;
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t2_fill_req", 32'(imem_req), 32'd1);
         check("t2_fill_addr", imem_addr, 32'(4 * k));
      end
      repeat (2) begin
         @(negedge clk);
         check("t2_full_req", 32'(imem_req), 32'd0);
         check("t2_full_addr", imem_addr, 32'h10);
         check("t2_head_hold", inst_pc, 32'h0);
      end
      @(posedge clk); #1;
      inst_ready = 1'b1;
      @(negedge clk);
      check("t2_resume_req", 32'(imem_req), 32'd1);
      wait_halt(40, "t2");

      // Redirect with a non-empty queue.
      inst_ready = 1'b0;
      reset_dut();
      repeat (3) begin @(posedge clk); #1; end
      redirect_valid = 1'b1; redirect_pc = 32'h14; inst_ready = 1'b1;
      restart(32'h14);
      @(negedge clk);
      check("t3_suppress_valid", 32'(inst_valid), 32'd0);
      check("t3_suppress_req", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      check("t3_n1_valid", 32'(inst_valid), 32'd0);
      check("t3_n1_addr", imem_addr, 32'h14);
      @(negedge clk);
      check("t3_n2_valid", 32'(inst_valid), 32'd1);
      check("t3_n2_pc", inst_pc, 32'h14);
      check("t3_n2_data", inst_data, 32'h0074a3a3);
      wait_halt(20, "t3");

      // Redirect out of halt with a misaligned target.
      check("t4_pre_halted", 32'(halted), 32'd1);
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 32'h0E;
      restart(32'h0E);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      check("t4_halt_clear", 32'(halted), 32'd0);
      check("t4_addr", imem_addr, 32'h0C);
      @(negedge clk);
      check("t4_pc", inst_pc, 32'h0C);
      check("t4_data", inst_data, 32'h0070c463);
      wait_halt(20, "t4");

      // Asynchronous reset pulse between edges with three entries queued.
      inst_ready = 1'b0;
      reset_dut();
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk); #1;
      rst = 1'b1;
      restart(32'h0);
      #1;
      check("t5_async_valid", 32'(inst_valid), 32'd0);
      check("t5_async_req", 32'(imem_req), 32'd0);
      check("t5_async_addr", imem_addr, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      check("t5_release_req", 32'(imem_req), 32'd1);
      check("t5_release_addr", imem_addr, 32'h0);
      inst_ready = 1'b1;
      @(negedge clk);
      check("t5_restart_pc", inst_pc, 32'h0);
      wait_halt(30, "t5");

      // PC wrap from the top of the address space.
      @(posedge clk); #1;
      rst2 = 1'b0;
      @(negedge clk);
      check("t6_req", 32'(imem_req2), 32'd1);
      check("t6_addr", imem_addr2, WRAP_PC);
      @(negedge clk);
      check("t6_pc0", inst_pc2, 32'hFFFF_FFF8);
      check("t6_data0", inst_data2, 32'h00100093);
      @(negedge clk);
      check("t6_pc1", inst_pc2, 32'hFFFF_FFFC);
      @(negedge clk);
      check("t6_pc2", inst_pc2, 32'h0000_0000);
      check("t6_data2", inst_data2, 32'h00300193);
      @(negedge clk);
      check("t6_halted", 32'(halted2), 32'd1);
      check("t6_halt_addr", imem_addr2, 32'h4);

      // Randomized traffic: random memory image, ready, redirects and reset pulses.
      for (int i = 0; i < 256; i++) begin
         mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
      end
      mem[255] = 32'h0;
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         redirect_valid = 1'b0;
         inst_ready = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 19);
         if (r == 0) begin
            redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FF);
            redirect_valid = 1'b1;
            restart(redirect_pc);
         end else if (r == 1 && $urandom_range(0, 9) == 0) begin
            #2;
            rst = 1'b1;
            restart(32'h0);
            #1;
            rst = 1'b0;
         end
      end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      wait_halt(600, "rand");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
